// File: rtl/pmp_pkg.sv
// Shared types for the PMP CSR file: cfg byte layout, CSR ops, addresses
// and the request FSM states.
package pmp_pkg;

    typedef enum logic [1:0] {
        PMP_OFF,
        PMP_TOR,
        PMP_NA4,
        PMP_NAPOT
    } pmp_mode_e;

    typedef struct packed {
        logic      l;
        logic [1:0] rsvd;
        pmp_mode_e a;
        logic      x;
        logic      w;
        logic      r;
    } pmp_cfg_t;

    typedef enum logic [1:0] {
        CSR_READ,
        CSR_WRITE,
        CSR_SET,
        CSR_CLEAR
    } csr_op_e;

    localparam logic [11:0] CSR_PMPCFG0  = 12'h3A0;
    localparam logic [11:0] CSR_PMPADDR0 = 12'h3B0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_COMMIT,
        ST_RESP
    } pmp_state_e;

endpackage

// File: rtl/pmp_cfg_warl.sv
// Legalises one pmpcfg byte: reserved bits cleared, W without R dropped,
// and a locked byte keeps its old value.
module pmp_cfg_warl
    import pmp_pkg::*;
(
    input  logic [7:0] old_cfg,
    input  logic [7:0] new_cfg,
    output logic [7:0] legal_cfg
);

    pmp_cfg_t old_c;
    pmp_cfg_t new_c;
    pmp_cfg_t legal_c;

    always_comb begin
        old_c   = pmp_cfg_t'(old_cfg);
        new_c   = pmp_cfg_t'(new_cfg);
        legal_c = new_c;
        legal_c.rsvd = 2'b00;
        if (!new_c.r && new_c.w) begin
            legal_c.w = 1'b0;
        end
        if (old_c.l) begin
            legal_c = old_c;
        end
    end

    assign legal_cfg = legal_c;

endmodule

// File: rtl/pmp_csr_file.sv
// PMP CSR file: pmpcfg/pmpaddr storage behind a 4-state request FSM,
// with WARL legalisation and L / TOR lock-through protection.
module pmp_csr_file
    import pmp_pkg::*;
#(
    parameter int NUM_ENTRIES = 16,
    parameter int XLEN        = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [11:0]              req_addr,
    input  logic [1:0]               req_op,
    input  logic [XLEN-1:0]          req_wdata,
    output logic                     resp_valid,
    output logic [XLEN-1:0]          resp_rdata,
    output logic                     resp_err,
    output logic [NUM_ENTRIES*32-1:0] pmp_addr_o,
    output logic [NUM_ENTRIES*2-1:0]  pmp_a_o,
    output logic [NUM_ENTRIES*3-1:0]  pmp_rwx_o,
    output logic [NUM_ENTRIES-1:0]    pmp_l_o
);

    pmp_state_e      state_q, state_d;
    logic [11:0]     raddr_q, raddr_d;
    csr_op_e         op_q, op_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] old_q, old_d;
    logic            err_q, err_d;
    logic            req_ready_q, req_ready_d;
    logic            resp_valid_q, resp_valid_d;
    logic            resp_err_q, resp_err_d;
    logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
    logic [7:0]      cfg_q [NUM_ENTRIES];
    logic [7:0]      cfg_d [NUM_ENTRIES];
    logic [31:0]     addr_q [NUM_ENTRIES];
    logic [31:0]     addr_d [NUM_ENTRIES];

    logic                   cfg_hit;
    logic                   addr_hit;
    logic [XLEN-1:0]        rd_word;
    logic [XLEN-1:0]        new_word;
    logic [31:0]            legal_word;
    logic [NUM_ENTRIES-1:0] lock;

    always_comb begin
        cfg_hit  = (raddr_q[11:4] == CSR_PMPCFG0[11:4])
                && ({1'b0, raddr_q[3:0]} < 5'(NUM_ENTRIES / 4));
        addr_hit = (raddr_q[11:4] == CSR_PMPADDR0[11:4])
                && ({1'b0, raddr_q[3:0]} < 5'(NUM_ENTRIES));
        rd_word  = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (cfg_hit && raddr_q[3:0] == 4'(i / 4)) begin
                rd_word[8*(i%4) +: 8] = cfg_q[i];
            end
            if (addr_hit && raddr_q[3:0] == 4'(i)) begin
                rd_word[31:0] = addr_q[i];
            end
        end
    end

    // An address is frozen by its own L, or by a locked TOR entry above it.
    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            lock[i] = cfg_q[i][7];
        end
        for (int i = 0; i < NUM_ENTRIES - 1; i++) begin
            if (cfg_q[i+1][7] && cfg_q[i+1][4:3] == PMP_TOR) begin
                lock[i] = 1'b1;
            end
        end
    end

    always_comb begin
        unique case (op_q)
            CSR_WRITE: new_word = wdata_q;
            CSR_SET:   new_word = old_q | wdata_q;
            CSR_CLEAR: new_word = old_q & ~wdata_q;
            default:   new_word = old_q;
        endcase
    end

    for (genvar j = 0; j < 4; j++) begin : g_warl
        pmp_cfg_warl u_warl (
            .old_cfg   (old_q[8*j +: 8]),
            .new_cfg   (new_word[8*j +: 8]),
            .legal_cfg (legal_word[8*j +: 8])
        );
    end

    always_comb begin
        state_d      = state_q;
        raddr_d      = raddr_q;
        op_d         = op_q;
        wdata_d      = wdata_q;
        old_d        = old_q;
        err_d        = err_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
        cfg_d        = cfg_q;
        addr_d       = addr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    raddr_d = req_addr;
                    op_d    = csr_op_e'(req_op);
                    wdata_d = req_wdata;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                err_d   = !(cfg_hit || addr_hit);
                old_d   = rd_word;
                state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                if (!err_q && op_q != CSR_READ) begin
                    for (int i = 0; i < NUM_ENTRIES; i++) begin
                        if (cfg_hit && raddr_q[3:0] == 4'(i / 4)) begin
                            cfg_d[i] = legal_word[8*(i%4) +: 8];
                        end
                        if (addr_hit && raddr_q[3:0] == 4'(i) && !lock[i]) begin
                            addr_d[i] = new_word[31:0];
                        end
                    end
                end
                resp_valid_d = 1'b1;
                resp_rdata_d = old_q;
                resp_err_d   = err_q;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        req_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            raddr_q      <= '0;
            op_q         <= CSR_READ;
            wdata_q      <= '0;
            old_q        <= '0;
            err_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                cfg_q[i]  <= '0;
                addr_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            raddr_q      <= raddr_d;
            op_q         <= op_d;
            wdata_q      <= wdata_d;
            old_q        <= old_d;
            err_q        <= err_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            cfg_q        <= cfg_d;
            addr_q       <= addr_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            pmp_addr_o[32*i +: 32] = addr_q[i];
            pmp_a_o[2*i +: 2]      = cfg_q[i][4:3];
            pmp_rwx_o[3*i +: 3]    = cfg_q[i][2:0];
            pmp_l_o[i]             = cfg_q[i][7];
        end
    end

endmodule

// File: tb/tb_pmp_csr_file.sv
// Randomised bench for pmp_csr_file against a CSR-level reference model,
// plus directed lock, WARL, error, reset-abort and back-to-back cases.
module tb_pmp_csr_file;

    localparam int N = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [11:0]     req_addr = '0;
    logic [1:0]      req_op = '0;
    logic [31:0]     req_wdata = '0;
    logic            resp_valid;
    logic [31:0]     resp_rdata;
    logic            resp_err;
    logic [N*32-1:0] pmp_addr_o;
    logic [N*2-1:0]  pmp_a_o;
    logic [N*3-1:0]  pmp_rwx_o;
    logic [N-1:0]    pmp_l_o;

    int nchk = 0;
    int nfail = 0;

    logic [7:0]  m_cfg [N];
    logic [31:0] m_addr [N];

    pmp_csr_file #(.NUM_ENTRIES(N), .XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_op     (req_op),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .pmp_addr_o (pmp_addr_o),
        .pmp_a_o    (pmp_a_o),
        .pmp_rwx_o  (pmp_rwx_o),
        .pmp_l_o    (pmp_l_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_cfg[i]  = '0;
            m_addr[i] = '0;
        end
    endtask

    // Reference behaviour of one CSR access; returns error flag and pre-op value.
    task automatic model_op(input logic [11:0] a, input logic [1:0] op,
                            input logic [31:0] wd, output logic err,
                            output logic [31:0] old);
        int ai;
        int k;
        logic [31:0] nw;
        logic [7:0] b;
        logic locked;
        ai  = int'(a);
        err = 1'b1;
        old = '0;
        k   = 0;
        if (ai >= 'h3A0 && ai < 'h3A0 + N / 4) begin
            err = 1'b0;
            k   = ai - 'h3A0;
            for (int j = 0; j < 4; j++) old[8*j +: 8] = m_cfg[4*k+j];
        end else if (ai >= 'h3B0 && ai < 'h3B0 + N) begin
            err = 1'b0;
            k   = ai - 'h3B0;
            old = m_addr[k];
        end
        if (!err && op != 2'd0) begin
            case (op)
                2'd1:    nw = wd;
                2'd2:    nw = old | wd;
                default: nw = old & ~wd;
            endcase
            if (ai < 'h3B0) begin
                for (int j = 0; j < 4; j++) begin
                    if (!m_cfg[4*k+j][7]) begin
                        b = nw[8*j +: 8];
                        b[6:5] = 2'b00;
                        if (b[1] && !b[0]) b[1] = 1'b0;
                        m_cfg[4*k+j] = b;
                    end
                end
            end else begin
                locked = m_cfg[k][7];
                if (k < N - 1) begin
                    if (m_cfg[k+1][7] && m_cfg[k+1][4:3] == 2'd1) locked = 1'b1;
                end
                if (!locked) m_addr[k] = nw;
            end
        end
    endtask

    task automatic chk_outputs(input string tag);
        logic [N*32-1:0] ea;
        logic [N*2-1:0]  em;
        logic [N*3-1:0]  ep;
        logic [N-1:0]    el;
        for (int i = 0; i < N; i++) begin
            ea[32*i +: 32] = m_addr[i];
            em[2*i +: 2]   = m_cfg[i][4:3];
            ep[3*i +: 3]   = m_cfg[i][2:0];
            el[i]          = m_cfg[i][7];
        end
        chk({tag, "_addr_o"}, pmp_addr_o, ea);
        chk({tag, "_a_o"}, pmp_a_o, em);
        chk({tag, "_rwx_o"}, pmp_rwx_o, ep);
        chk({tag, "_l_o"}, pmp_l_o, el);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic xact(input logic [11:0] a, input logic [1:0] op,
                        input logic [31:0] wd);
        logic e;
        logic [31:0] o;
        int n;
        model_op(a, op, wd, e, o);
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = a;
        req_op    = op;
        req_wdata = wd;
        n = 0;
        while (!req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("ready_idle", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("fetch_hs", {req_ready, resp_valid}, 2'b00);
        @(negedge clk);
        chk("commit_hs", {req_ready, resp_valid}, 2'b00);
        @(negedge clk);
        chk("resp_hs", {req_ready, resp_valid}, 2'b01);
        chk("rdata", resp_rdata, o);
        chk("err", resp_err, e);
        chk_outputs("post");
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int nr;
        int nrdy;
        int sel;
        logic [11:0] a;
        logic [31:0] wd;

        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_resp", {resp_valid, resp_err}, 2'b00);
        chk("rst_rdata", resp_rdata, 0);
        chk_outputs("rst");

        xact(12'h3B0, 2'd0, 32'h0);

        xact(12'h3A0, 2'd1, 32'h0000001F);
        xact(12'h3A0, 2'd0, 32'h0);
        chk("napot_rd", resp_rdata, 32'h1F);
        chk("napot_a0", pmp_a_o[1:0], 2'b11);
        chk("napot_rwx0", pmp_rwx_o[2:0], 3'b111);
        xact(12'h3A0, 2'd2, 32'h00000100);
        chk("set_old", resp_rdata, 32'h1F);
        xact(12'h3A0, 2'd0, 32'h0);
        chk("set_rd", resp_rdata, 32'h11F);

        xact(12'h3A0, 2'd1, 32'h00000062);
        xact(12'h3A0, 2'd0, 32'h0);
        chk("warl_62", resp_rdata, 32'h0);
        xact(12'h3A0, 2'd1, 32'h00000003);
        xact(12'h3A0, 2'd0, 32'h0);
        chk("warl_03", resp_rdata, 32'h3);

        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 12'h3B2;
        req_op    = 2'd1;
        req_wdata = 32'hFFFF;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        nr = 0;
        repeat (2) begin
            @(negedge clk);
            if (resp_valid) nr++;
        end
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid) nr++;
        end
        chk("abort_noresp", nr, 0);
        chk("abort_ready", req_ready, 1);
        chk("abort_addr2", pmp_addr_o[95:64], 32'h0);
        chk_outputs("abort");

        xact(12'h3A0, 2'd1, 32'h00008F00);
        xact(12'h3B1, 2'd1, 32'h00001234);
        xact(12'h3B0, 2'd1, 32'h00005678);
        xact(12'h3B1, 2'd0, 32'h0);
        chk("lock_a1", resp_rdata, 32'h0);
        xact(12'h3B0, 2'd0, 32'h0);
        chk("tor_a0", resp_rdata, 32'h0);
        xact(12'h3A0, 2'd3, 32'hFFFFFFFF);
        xact(12'h3A0, 2'd0, 32'h0);
        chk("lock_clr", resp_rdata, 32'h8F00);
        xact(12'h3B2, 2'd1, 32'hABCD);

        xact(12'h3C0, 2'd0, 32'h0);
        chk("err_3c0", {resp_err, resp_rdata}, {1'b1, 32'h0});
        xact(12'h3B8, 2'd1, 32'hFFFF);
        chk("err_3b8", {resp_err, resp_rdata}, {1'b1, 32'h0});
        xact(12'h3A2, 2'd1, 32'hFF);
        chk("err_3a2", resp_err, 1);

        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 12'h3B2;
        req_op    = 2'd0;
        nr = 0;
        nrdy = 0;
        repeat (12) begin
            @(negedge clk);
            if (resp_valid) nr++;
            if (req_ready) nrdy++;
        end
        req_valid = 1'b0;
        chk("b2b_resp", nr, 3);
        chk("b2b_ready", nrdy, 3);

        for (int t = 0; t < 240; t++) begin
            if (t % 60 == 0) do_reset();
            sel = $urandom_range(0, 9);
            if (sel < 3) a = 12'h3A0 + 12'($urandom_range(0, 3));
            else if (sel < 9) a = 12'h3B0 + 12'($urandom_range(0, 15));
            else a = 12'($urandom());
            wd = $urandom();
            if ($urandom_range(0, 3) != 0) wd = wd & 32'h7F7F7F7F;
            xact(a, 2'($urandom()), wd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule
